// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed, active-low 4-digit seven-segment display.
// Samples each strobe once it has settled and rebuilds the shown hex frame.
module seg_scan_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        stale
);

  localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [23:0] STALE_AT    = 24'(TIMEOUT - 1);
  localparam logic [23:0] TCNT_MAX    = '1;

  typedef enum logic {
    COLLECT,
    PUBLISH
  } state_t;

  state_t      state;
  logic [3:0]  an_q;
  logic [3:0]  an_prev;
  logic [6:0]  seg_q;
  logic [6:0]  seg_prev;
  logic [7:0]  scnt;
  logic [23:0] tcnt;
  logic [3:0]  seen;
  logic [15:0] shadow_nib;
  logic [3:0]  shadow_blank;
  logic [3:0]  shadow_err;

  logic        one_low;
  logic [1:0]  slot;
  logic [3:0]  slot_mask;
  logic        steady;
  logic        capture;
  logic [3:0]  dec_nib;
  logic        dec_blank;
  logic        dec_err;

  // Only a strobe with exactly one anode driven low names a digit slot.
  always_comb begin
    one_low = 1'b1;
    slot    = 2'd0;
    case (an_q)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign slot_mask = 4'b0001 << slot;
  assign steady    = (an_q == an_prev) && (seg_q == seg_prev) && one_low;
  // scnt saturates at SETTLE, so this fires once per settled strobe.
  assign capture   = steady && (scnt == SETTLE_LAST);

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_q)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      7'h7F: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q     <= '0;
      seg_q    <= '0;
      an_prev  <= '0;
      seg_prev <= '0;
      scnt     <= '0;
      tcnt     <= '0;
    end else begin
      an_q     <= an;
      seg_q    <= seg;
      an_prev  <= an_q;
      seg_prev <= seg_q;
      if (!steady) begin
        scnt <= '0;
      end else if (scnt < SETTLE_MAX) begin
        scnt <= scnt + 8'd1;
      end
      if (capture) begin
        tcnt <= '0;
      end else if (tcnt != TCNT_MAX) begin
        tcnt <= tcnt + 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_nib   <= '0;
      shadow_blank <= '0;
      shadow_err   <= '0;
    end else if (capture) begin
      shadow_nib[{slot, 2'b00} +: 4] <= dec_nib;
      shadow_blank[slot]             <= dec_blank;
      shadow_err[slot]               <= dec_err;
    end
  end

  // A capture landing in PUBLISH starts the next frame after seen is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      seen        <= '0;
      digits      <= '0;
      blank       <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
      stale       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (!capture && (tcnt >= STALE_AT)) begin
        stale <= 1'b1;
      end
      case (state)
        COLLECT: begin
          if (capture) begin
            seen <= seen | slot_mask;
            if ((seen | slot_mask) == 4'hF) begin
              state <= PUBLISH;
            end
          end
        end
        PUBLISH: begin
          digits      <= shadow_nib;
          blank       <= shadow_blank;
          err         <= shadow_err;
          frame_valid <= 1'b1;
          stale       <= 1'b0;
          seen        <= capture ? slot_mask : 4'h0;
          state       <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side of the multiplexed 4-digit seven-segment interface driven by `game` (an/seg): watches the anode strobes and segment lines and reconstructs the displayed hex digits.
- Used as a self-checking monitor in benches and as an on-chip readback of the display state.
- Requires each strobe to be stable for a settle window before sampling.
- Assembles a full frame once all four digits have been sampled, and flags loss of scanning.

Parameters:
- SETTLE, 4: consecutive cycles (after the first) an/seg must be unchanged before a sample is taken; range 1..255.
- TIMEOUT, 1048576: cycles without any capture before `stale` asserts; range 2..2^24.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- an  in  4  anode strobes, active-low; an[3] = leftmost digit
- seg  in  7  segments, active-low; seg[0]=a … seg[6]=g
- digits  out  16  last complete frame; [15:12]=digit under an[3] … [3:0]=an[0]
- blank  out  4  per-digit: segment pattern was all-off (7'h7F); digit nibble 0
- err  out  4  per-digit: pattern not in decode table and not blank; digit nibble 0
- frame_valid  out  1  one-cycle pulse when digits/blank/err update
- stale  out  1  no capture for TIMEOUT cycles

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): digits=0, blank=0, err=0, frame_valid=0, stale=0. All internal state cleared: prev an/seg, stable counter, seen mask, shadow registers, timeout counter. Reset mid-frame discards partial captures.
- Input registers: an_q/seg_q, registered each cycle; all logic works on the registered values.
- Stability counter `scnt`, 8 bits:
  - Cleared when an_q≠prev an_q or seg_q≠prev seg_q.
  - Also cleared when an_q is not exactly one bit low (0, 2, 3 or 4 bits low).
  - Otherwise increments, saturating at SETTLE.
- Capture: on the cycle `scnt` transitions to SETTLE, for the index i where an_q[i]=0:
  - Write decoded nibble, blank bit and err bit into shadow slot i; set seen[i].
  - Exactly one capture per stable strobe; no re-capture until `scnt` clears.
- Decode table, seg active-low hex → value:
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - 7F → blank=1, nibble 0.
  - Anything else → err=1, nibble 0.
- Frame states: COLLECT → PUBLISH → COLLECT.
  - COLLECT: if a capture makes seen==4'b1111, go to PUBLISH.
  - PUBLISH (one cycle): copy shadow to digits/blank/err; frame_valid=1; seen cleared; stale cleared; return to COLLECT.
  - A capture arriving in the PUBLISH cycle is recorded into the next frame (seen bit set after the clear).
- Re-capture of a digit already in `seen` overwrites its shadow slot (latest value wins). A frame needs all four slots, not four captures.
- Latency: frame_valid asserts 1 cycle after the 4th distinct-slot capture; outputs update on that same edge.
- Timeout counter, 24 bits:
  - Cleared on every capture; otherwise increments, saturating.
  - stale=1 once count ≥ TIMEOUT−1 with no capture. Held until next frame_valid or rst.
  - digits hold their last value while stale.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst 3 cycles with arbitrary an/seg → digits=0, blank=0, err=0, frame_valid=0, stale=0.
- Normal scan, SETTLE=4, 20 cycles per digit:
  - an=1110/seg=30, an=1101/seg=24, an=1011/seg=79, an=0111/seg=40.
  - → single frame_valid pulse, digits=16'h0123, blank=0, err=0; next identical scan → another pulse, same value.
- Glitch rejection:
  - Strobe an=1110/seg=12 held only 3 cycles (SETTLE=4), then seg changes → no capture, seen unchanged.
  - Hold 6 cycles → capture 5.
  - an=1100 (two low) held 50 cycles → no capture.
- Blank/err: digit1 seg=7F, digit2 seg=55, others 0E → digits=16'hF00F, blank=4'b0010, err=4'b0100.
- Overwrite plus reset:
  - Capture digit0=3, then digit0=7, then digits 1–3=8 → digits=16'h8887.
  - Assert rst after two captures of the next frame → no frame_valid until four fresh captures.
- Stale, TIMEOUT=64: complete one frame, then hold an=1111 → stale=1 by cycle 64 after last capture, digits unchanged; resume scanning → stale clears with next frame_valid.
